// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_pkg.sv
// Shared definitions for switchable fillcap bank controllers: state encoding and
// the count-to-thermometer mapping used to drive segment enables.
package gf180mcu_fd_sc_mcu9t5v0__fillcap_pkg;

  localparam int MAX_SEG = 32;
  localparam int CNT_W   = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Bit i is set iff i < count; bits at or above n_seg are always clear.
  function automatic logic [MAX_SEG-1:0] therm(input logic [CNT_W-1:0] count, input int n_seg);
    logic [MAX_SEG-1:0] vec_s;
    vec_s = {MAX_SEG{1'b0}};
    for (int i = 0; i < MAX_SEG; i++) begin
      vec_s[i] = (i < int'(count)) && (i < n_seg);
    end
    return vec_s;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq_if.sv
// Target/status bundle between a fillcap bank sequencer and its controller.
interface gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq_if #(
  parameter int N_SEG = 8
) ();
  localparam int SEG_W = $clog2(N_SEG + 1);

  logic [SEG_W-1:0] tgt;
  logic             hold;
  logic [N_SEG-1:0] seg_en;
  logic [SEG_W-1:0] cur;
  logic             busy;
  logic             done;

  modport master (output tgt, hold, input seg_en, cur, busy, done);
  modport slave  (input tgt, hold, output seg_en, cur, busy, done);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_step_tmr.sv
// Step-interval down-counter: load to STEP_CYC-1, count down while enabled, flag at zero.
module gf180mcu_fd_sc_mcu9t5v0__fillcap_step_tmr #(
  parameter int STEP_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic dec,
  output logic expired
);
  // A one-cycle interval still needs a one-bit counter that simply stays at zero.
  localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(STEP_CYC - 1);
  localparam logic [TW-1:0] ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0] ONE    = TW'(1);

  logic [TW-1:0] cnt_r;

  // Counter register: clear beats load beats decrement; saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (clr) begin
      cnt_r <= ZERO;
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (dec && (cnt_r != ZERO)) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == ZERO);
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq.sv
// Staged enable sequencer for a switchable decap bank: walks the active-segment count
// toward the (saturated) target one segment per step interval to bound inrush.
module gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq
  import gf180mcu_fd_sc_mcu9t5v0__fillcap_pkg::*;
#(
  parameter int N_SEG    = 8,
  parameter int STEP_CYC = 16,
  parameter bit FAST_OFF = 1'b0
) (
`ifdef USE_POWER_PINS
  inout wire vdd,
  inout wire vss,
`endif
  input logic clk,
  input logic rst,
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq_if.slave bus
);
  localparam int SEG_W = $clog2(N_SEG + 1);
  localparam logic [SEG_W-1:0] MAX_CNT  = SEG_W'(N_SEG);
  localparam logic [SEG_W-1:0] CNT_ZERO = {SEG_W{1'b0}};
  localparam logic [SEG_W-1:0] CNT_ONE  = SEG_W'(1);

  state_e           state_r, state_s;
  logic [SEG_W-1:0] cur_r, cur_s, tgt_r, tgt_sat_s;
  logic [N_SEG-1:0] seg_en_r;
  logic             busy_r, done_r, done_s;
  logic             tmr_load_s, tmr_clr_s, tmr_dec_s, tmr_exp_s;

  gf180mcu_fd_sc_mcu9t5v0__fillcap_step_tmr #(.STEP_CYC(STEP_CYC)) u_step_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load_s),
    .clr     (tmr_clr_s),
    .dec     (tmr_dec_s),
    .expired (tmr_exp_s)
  );

  // Clamp the requested count to the physical segment count.
  always_comb begin
    if (bus.tgt > MAX_CNT) begin
      tgt_sat_s = MAX_CNT;
    end else begin
      tgt_sat_s = bus.tgt;
    end
  end

  // Next-state, next-count and timer control; direction is re-decided at every expiry.
  always_comb begin
    state_s    = state_r;
    cur_s      = cur_r;
    done_s     = 1'b0;
    tmr_load_s = 1'b0;
    tmr_clr_s  = 1'b0;
    tmr_dec_s  = 1'b0;
    if (FAST_OFF && (tgt_r < cur_r)) begin
      state_s   = ST_IDLE;
      cur_s     = tgt_r;
      done_s    = 1'b1;
      tmr_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tgt_r != cur_r) begin
            state_s    = ST_WAIT;
            tmr_load_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.hold) begin
            state_s = ST_WAIT;
          end else if (!tmr_exp_s) begin
            tmr_dec_s = 1'b1;
          end else begin
            if (tgt_r > cur_r) begin
              cur_s = cur_r + CNT_ONE;
            end else if (tgt_r < cur_r) begin
              cur_s = cur_r - CNT_ONE;
            end else begin
              cur_s = cur_r;
            end
            if (cur_s == tgt_r) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end else begin
              tmr_load_s = 1'b1;
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; enables are decoded from the next count so they track CUR exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cur_r    <= CNT_ZERO;
      tgt_r    <= CNT_ZERO;
      seg_en_r <= {N_SEG{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cur_r    <= cur_s;
      tgt_r    <= tgt_sat_s;
      seg_en_r <= N_SEG'(therm(CNT_W'(cur_s), N_SEG));
      busy_r   <= (state_s == ST_WAIT);
      done_r   <= done_s;
    end
  end

  assign bus.seg_en = seg_en_r;
  assign bus.cur    = cur_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq.sv
// Scoreboard bench: three sequencer instances; expected enable changes and DONE cycles are
// queued when the target is driven and matched as the outputs move.
module tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq;
  typedef struct {
    int         cyc;
    logic [7:0] seg;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ev_t        qs[3][$];
  int         qd[3][$];
  logic [7:0] last_seg[3] = '{8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq_if #(.N_SEG(8)) ifa ();
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq_if #(.N_SEG(8)) ifb ();
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq_if #(.N_SEG(8)) ifc ();

  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq #(.N_SEG(8), .STEP_CYC(4), .FAST_OFF(1'b0)) u_a (
    .clk(clk), .rst(rst), .bus(ifa));
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq #(.N_SEG(8), .STEP_CYC(4), .FAST_OFF(1'b1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb));
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq #(.N_SEG(8), .STEP_CYC(1), .FAST_OFF(1'b0)) u_c (
    .clk(clk), .rst(rst), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] th(input int n);
    logic [8:0] v;
    v = (9'd1 << n) - 9'd1;
    return v[7:0];
  endfunction

  // Queue a plain stepped ramp started by driving the target at edge count t0.
  task automatic ramp(input int id, input int t0, input int s, input int from, input int to,
                      input bit with_done);
    int n;
    int v;
    ev_t e;
    n = (to > from) ? to - from : from - to;
    for (int i = 1; i <= n; i++) begin
      v = (to > from) ? from + i : from - i;
      e.cyc = t0 + 2 + s * i;
      e.seg = th(v);
      qs[id].push_back(e);
    end
    if (with_done) qd[id].push_back(t0 + 2 + s * n);
  endtask

  task automatic push_ev(input int id, input int c, input logic [7:0] seg);
    ev_t e;
    e.cyc = c;
    e.seg = seg;
    qs[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic [7:0] seg, input logic [3:0] cur, input logic done);
    ev_t e;
    chk($sformatf("therm%0d", id), seg, th(int'(cur)));
    if (seg !== last_seg[id]) begin
      if (qs[id].size() == 0) begin
        chk($sformatf("unexp_seg%0d", id), seg, last_seg[id]);
      end else begin
        e = qs[id].pop_front();
        chk($sformatf("seg%0d", id), seg, e.seg);
        chk($sformatf("seg_cyc%0d", id), cyc, e.cyc);
      end
      last_seg[id] = seg;
    end
    if (done !== 1'b0) begin
      if (qd[id].size() == 0) chk($sformatf("unexp_done%0d", id), done, 1'b0);
      else chk($sformatf("done_cyc%0d", id), cyc, qd[id].pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.seg_en, ifa.cur, ifa.done);
    mon(1, ifb.seg_en, ifb.cur, ifb.done);
    mon(2, ifc.seg_en, ifc.cur, ifc.done);
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    ifa.tgt = 4'd5; ifa.hold = 1'b0;
    ifb.tgt = 4'd0; ifb.hold = 1'b0;
    ifc.tgt = 4'd0; ifc.hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cur", ifa.cur, 4'd0);
    chk("rst_seg", ifa.seg_en, 8'h00);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_done", ifa.done, 1'b0);

    // Release with a pending target: ramp 0->5.
    t0 = cyc; rst = 1'b0;
    ramp(0, t0, 4, 0, 5, 1'b1);
    wait_to(t0 + 3);
    chk("busy_ramp", ifa.busy, 1'b1);
    wait_to(t0 + 22);
    chk("busy_after5", ifa.busy, 1'b0);
    chk("cur5", ifa.cur, 4'd5);

    // Stepped ramp-down 5->3, then 3->0.
    t0 = cyc; ifa.tgt = 4'd3; ramp(0, t0, 4, 5, 3, 1'b1); wait_to(t0 + 11);
    t0 = cyc; ifa.tgt = 4'd0; ramp(0, t0, 4, 3, 0, 1'b1); wait_to(t0 + 15);

    // Ramp 0->3: steps at +5,+9,+13 after the sampling edge.
    t0 = cyc; ifa.tgt = 4'd3; ramp(0, t0, 4, 0, 3, 1'b1);
    wait_to(t0 + 15);
    chk("busy_after3", ifa.busy, 1'b0);

    // Saturating target with a 10-cycle hold after the first step.
    t0 = cyc; ifa.tgt = 4'd15;
    push_ev(0, t0 + 6, 8'h0F);
    push_ev(0, t0 + 20, 8'h1F);
    push_ev(0, t0 + 24, 8'h3F);
    push_ev(0, t0 + 28, 8'h7F);
    push_ev(0, t0 + 32, 8'hFF);
    qd[0].push_back(t0 + 32);
    wait_to(t0 + 7); ifa.hold = 1'b1;
    wait_to(t0 + 17); ifa.hold = 1'b0;
    wait_to(t0 + 33);
    chk("cur_sat", ifa.cur, 4'd8);

    // Retarget mid-ramp: toward 6, drop target to 2 at CUR=4, stepped descent.
    rst = 1'b1; ifa.tgt = 4'd6; push_ev(0, cyc + 1, 8'h00);
    @(negedge clk);
    t0 = cyc; rst = 1'b0;
    ramp(0, t0, 4, 0, 4, 1'b0);
    push_ev(0, t0 + 22, 8'h07);
    push_ev(0, t0 + 26, 8'h03);
    qd[0].push_back(t0 + 26);
    wait_to(t0 + 18);
    chk("cur_retgt", ifa.cur, 4'd4);
    ifa.tgt = 4'd2;
    wait_to(t0 + 27);
    chk("cur_down2", ifa.cur, 4'd2);
    chk("busy_down2", ifa.busy, 1'b0);

    // Reset mid-ramp at CUR=5: segments drop on the next edge, no DONE.
    t0 = cyc; ifa.tgt = 4'd8;
    ramp(0, t0, 4, 2, 5, 1'b0);
    wait_to(t0 + 14);
    chk("cur_pre_rst", ifa.cur, 4'd5);
    rst = 1'b1; push_ev(0, t0 + 15, 8'h00);
    wait_to(t0 + 15);
    chk("busy_rst", ifa.busy, 1'b0);
    ifa.tgt = 4'd0;
    repeat (2) @(negedge clk);
    chk("cur_rst", ifa.cur, 4'd0);
    rst = 1'b0;

    // Fast-off instance: ramp toward 6, at CUR=4 drop to 2 -> immediate jump.
    t0 = cyc; ifb.tgt = 4'd6;
    ramp(1, t0, 4, 0, 4, 1'b0);
    push_ev(1, t0 + 20, 8'h03);
    qd[1].push_back(t0 + 20);
    wait_to(t0 + 18);
    chk("b_cur4", ifb.cur, 4'd4);
    ifb.tgt = 4'd2;
    wait_to(t0 + 21);
    chk("b_cur2", ifb.cur, 4'd2);
    chk("b_busy", ifb.busy, 1'b0);
    t0 = cyc; ifb.tgt = 4'd0;
    push_ev(1, t0 + 2, 8'h00);
    qd[1].push_back(t0 + 2);
    wait_to(t0 + 3);

    // One-cycle step interval: 0->8, DONE nine cycles after the sampling edge.
    t0 = cyc; ifc.tgt = 4'd8;
    ramp(2, t0, 1, 0, 8, 1'b1);
    wait_to(t0 + 11);
    chk("c_cur8", ifc.cur, 4'd8);
    chk("c_busy", ifc.busy, 1'b0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("seg_left%0d", i), qs[i].size(), 0);
      chk($sformatf("done_left%0d", i), qd[i].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
